// File: rtl/mole_pkg.sv
// Shared defaults and helpers for the whack-a-mole button scanner.
// Optional release events: define MOLE_BTN_RELEASE_EN.
package mole_pkg;

  localparam int N_BTN_DEF    = 4;
  localparam int TICK_DIV_DEF = 100000;
  localparam int DB_CNT_DEF   = 8;

  typedef logic [$clog2(N_BTN_DEF)-1:0] btn_idx_t;

  function automatic btn_idx_t lowest_set(
    input logic [N_BTN_DEF-1:0] mask
  );
    btn_idx_t r;
    r = '0;
    for (int i = N_BTN_DEF-1; i >= 0; i--) begin
      if (mask[i]) r = btn_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, tick-driven debounce counter, edge pulses.
// fall_o exists only when MOLE_BTN_RELEASE_EN is defined.
module btn_debounce
  import mole_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
`ifdef MOLE_BTN_RELEASE_EN
  output logic fall_o,
`endif
  output logic rise_o
);

  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CNT-1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          sync;
  logic          diff;
  logic          flip;

  assign sync = sync_q[1];
  assign diff = sync != level_q;
  // Level changes on the edge ending this cycle.
  assign flip = tick_i && diff && (cnt_q == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (tick_i) begin
        if (!diff) begin
          cnt_q <= '0;
        end else if (cnt_q == CMAX) begin
          level_q <= sync;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = flip && sync;
`ifdef MOLE_BTN_RELEASE_EN
  assign fall_o  = flip && !sync;
`endif

endmodule

// File: rtl/mole_button_scanner.sv
// Debounced button scanner queuing hit events for the game FSM.
// MOLE_BTN_RELEASE_EN adds hit_release and queues release events too.
module mole_button_scanner
  import mole_pkg::*;
#(
  parameter int N_BTN    = N_BTN_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DB_CNT   = DB_CNT_DEF,
  localparam int IW      = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  output logic [N_BTN-1:0] btn_level,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [IW-1:0]    hit_idx,
`ifdef MOLE_BTN_RELEASE_EN
  output logic             hit_release,
`endif
  output logic             overrun
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV-1);

  logic [PW-1:0]    pre_q;
  logic             tick;
  logic [N_BTN-1:0] rise;

  logic [N_BTN-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ovr_q, ovr_d;
  logic             free;

`ifdef MOLE_BTN_RELEASE_EN
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] rel_q, rel_d;
  logic             isrel_q, isrel_d;
`endif

  function automatic logic [IW-1:0] low_idx(
    input logic [N_BTN-1:0] m
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = N_BTN-1; i >= 0; i--) begin
      if (m[i]) r = IW'(i);
    end
    return r;
  endfunction

  assign tick = (pre_q == PMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else if (tick) pre_q <= '0;
    else pre_q <= pre_q + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CNT(DB_CNT)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_raw[g]),
      .tick_i (tick),
      .level_o(btn_level[g]),
`ifdef MOLE_BTN_RELEASE_EN
      .fall_o (fall[g]),
`endif
      .rise_o (rise[g])
    );
  end

  assign free = !valid_q || hit_ready;

  always_comb begin
    pend_d  = pend_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ovr_d   = 1'b0;
`ifdef MOLE_BTN_RELEASE_EN
    rel_d   = rel_q;
    isrel_d = isrel_q;
`endif
    if (!enable) begin
      pend_d  = '0;
      valid_d = 1'b0;
`ifdef MOLE_BTN_RELEASE_EN
      rel_d   = '0;
`endif
    end else begin
      if (free) begin
        if (|pend_q) begin
          valid_d = 1'b1;
          idx_d   = low_idx(pend_q);
          pend_d[low_idx(pend_q)] = 1'b0;
`ifdef MOLE_BTN_RELEASE_EN
          isrel_d = 1'b0;
        end else if (|rel_q) begin
          valid_d = 1'b1;
          idx_d   = low_idx(rel_q);
          rel_d[low_idx(rel_q)] = 1'b0;
          isrel_d = 1'b1;
`endif
        end else begin
          valid_d = 1'b0;
        end
      end
      // New edges are merged after the load so a same-bit set wins.
      ovr_d  = |(rise & pend_q);
      pend_d = pend_d | rise;
`ifdef MOLE_BTN_RELEASE_EN
      rel_d  = rel_d | fall;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef MOLE_BTN_RELEASE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q   <= '0;
      isrel_q <= 1'b0;
    end else begin
      rel_q   <= rel_d;
      isrel_q <= isrel_d;
    end
  end

  assign hit_release = isrel_q;
`endif

  assign hit_valid = valid_q;
  assign hit_idx   = idx_q;
  assign overrun   = ovr_q;

endmodule
